// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the core (master)
// and the memory responder (slave).
interface data_mem_responder_if #(
  parameter int BIT_COUNT = 32,
  parameter int WORD_SIZE = 32
);
  logic                     MemEn;
  logic                     MemWrite;
  logic [WORD_SIZE/8-1:0]   ByteEn;
  logic [BIT_COUNT-1:0]     MemAdr;
  logic [WORD_SIZE-1:0]     MemWriteData;
  logic                     MemReady;
  logic                     MemValid;
  logic [WORD_SIZE-1:0]     MemReadData;
  logic                     MemError;

  modport master (
    output MemEn, MemWrite, ByteEn, MemAdr, MemWriteData,
    input  MemReady, MemValid, MemReadData, MemError
  );

  modport slave (
    input  MemEn, MemWrite, ByteEn, MemAdr, MemWriteData,
    output MemReady, MemValid, MemReadData, MemError
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder with byte-lane writes and a
// ready/valid handshake; IDLE -> WAIT -> RESP per request.
module data_mem_responder #(
  parameter int BIT_COUNT   = 32,
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus
);
  localparam int NB       = WORD_SIZE / 8;
  localparam int AW       = $clog2(DEPTH_WORDS);
  localparam int CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [BIT_COUNT-1:0] ADR_LIMIT =
    BIT_COUNT'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t r_state;
  state_t w_state_n;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_n;

  logic                 r_we;
  logic [NB-1:0]        r_be;
  logic [BIT_COUNT-1:0] r_adr;
  logic [WORD_SIZE-1:0] r_wd;
  logic [WORD_SIZE-1:0] r_rdata;
  logic                 r_err;

  logic [WORD_SIZE-1:0] r_mem [DEPTH_WORDS];

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_resp_n;
  logic                 w_s_we;
  logic [NB-1:0]        w_s_be;
  logic [BIT_COUNT-1:0] w_s_adr;
  logic [WORD_SIZE-1:0] w_s_wd;
  logic [AW-1:0]        w_idx;
  logic                 w_err;
  logic                 w_commit;

  assign w_ready  = (r_state != WAIT);
  assign w_accept = bus.MemEn & w_ready;

  // With single-cycle latency RESP is entered on the acceptance
  // edge itself, so the live request is serviced directly.
  assign w_s_we  = (LATENCY == 1) ? bus.MemWrite     : r_we;
  assign w_s_be  = (LATENCY == 1) ? bus.ByteEn       : r_be;
  assign w_s_adr = (LATENCY == 1) ? bus.MemAdr       : r_adr;
  assign w_s_wd  = (LATENCY == 1) ? bus.MemWriteData : r_wd;

  assign w_idx = w_s_adr[AW+1:2];
  assign w_err = (|w_s_adr[1:0])
               | (w_s_adr >= ADR_LIMIT)
               | (w_s_we & ~(|w_s_be));

  assign w_resp_n = (w_state_n == RESP);
  assign w_commit = reset & w_resp_n & w_s_we & ~w_err;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      WAIT: begin
        if (r_cnt == 4'd0) w_state_n = RESP;
        else               w_cnt_n   = r_cnt - 4'd1;
      end
      IDLE, RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_n = RESP;
          end else begin
            w_state_n = WAIT;
            w_cnt_n   = 4'(CNT_LOAD);
          end
        end else begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_adr   <= '0;
      r_wd    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_accept) begin
        r_we  <= bus.MemWrite;
        r_be  <= bus.ByteEn;
        r_adr <= bus.MemAdr;
        r_wd  <= bus.MemWriteData;
      end
      if (w_resp_n) begin
        r_err <= w_err;
        if (w_err || w_s_we) r_rdata <= '0;
        else                 r_rdata <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < NB; i++) begin
        if (w_s_be[i]) r_mem[w_idx][8*i +: 8] <= w_s_wd[8*i +: 8];
      end
    end
  end

  assign bus.MemReady    = w_ready;
  assign bus.MemValid    = (r_state == RESP);
  assign bus.MemReadData = r_rdata;
  assign bus.MemError    = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: LATENCY=2 responder plus a LATENCY=1 responder
// under continuous traffic.
module tb_data_mem_responder;
  localparam int LAT0 = 2;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  data_mem_responder_if #(.BIT_COUNT(32), .WORD_SIZE(32)) b0 ();
  data_mem_responder_if #(.BIT_COUNT(32), .WORD_SIZE(32)) b1 ();

  data_mem_responder #(
    .BIT_COUNT(32), .WORD_SIZE(32),
    .DEPTH_WORDS(1024), .LATENCY(LAT0)
  ) u0 (
    .clk(clk), .reset(rst_n), .bus(b0)
  );

  data_mem_responder #(
    .BIT_COUNT(32), .WORD_SIZE(32),
    .DEPTH_WORDS(1024), .LATENCY(1)
  ) u1 (
    .clk(clk), .reset(rst_n), .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic monitor0();
    exp_t e;
    forever begin
      @(negedge clk);
      if (b0.MemValid === 1'b1) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL l2_unexpected_valid actual=1 required=0 cyc=%0d",
                   cyc);
        end else begin
          e = q0.pop_front();
          chk("l2_rdata", b0.MemReadData, e.d);
          chk("l2_error", b0.MemError, e.e);
          chk("l2_cycle", cyc, e.c);
        end
      end
    end
  endtask

  task automatic monitor1();
    exp_t e;
    forever begin
      @(negedge clk);
      if (b1.MemValid === 1'b1) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL l1_unexpected_valid actual=1 required=0 cyc=%0d",
                   cyc);
        end else begin
          e = q1.pop_front();
          chk("l1_rdata", b1.MemReadData, e.d);
          chk("l1_error", b1.MemError, e.e);
          chk("l1_cycle", cyc, e.c);
        end
      end
    end
  endtask

  initial monitor0();
  initial monitor1();

  task automatic issue0(input bit we, input logic [3:0] be,
                        input logic [31:0] adr, input logic [31:0] wd,
                        input logic [31:0] ed, input bit ee,
                        input bit want, output int waits);
    waits = 0;
    @(negedge clk);
    b0.MemEn        = 1'b1;
    b0.MemWrite     = we;
    b0.ByteEn       = be;
    b0.MemAdr       = adr;
    b0.MemWriteData = wd;
    while (b0.MemReady !== 1'b1) begin
      if (waits >= 40) begin
        tests++;
        fails++;
        $display("FAIL l2_ready_timeout actual=0 required=1");
        b0.MemEn = 1'b0;
        return;
      end
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    b0.MemEn = 1'b0;
    if (want) q0.push_back('{ed, ee, cyc + LAT0 - 1});
  endtask

  task automatic drain();
    int n = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout actual=%0d required=0",
                 q0.size() + q1.size());
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // LATENCY=1 continuous traffic: we, be, adr, wd, expected data, error
  bit          l1_we [7] = '{1, 0, 1, 0, 0, 1, 0};
  logic [3:0]  l1_be [7] = '{4'hF, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [31:0] l1_ad [7] = '{32'h8, 32'h8, 32'h8, 32'h8,
                             32'h3, 32'hC, 32'h1000};
  logic [31:0] l1_wd [7] = '{32'h12345678, 32'h0, 32'hFF000000,
                             32'h0, 32'h0, 32'h77777777, 32'h0};
  logic [31:0] l1_ed [7] = '{32'h0, 32'h12345678, 32'h0,
                             32'hFF345678, 32'h0, 32'h0, 32'h0};
  bit          l1_ee [7] = '{0, 0, 0, 0, 1, 1, 1};

  initial begin
    int w;
    b0.MemEn = 1'b0; b0.MemWrite = 1'b0; b0.ByteEn = 4'h0;
    b0.MemAdr = 32'h0; b0.MemWriteData = 32'h0;
    b1.MemEn = 1'b0; b1.MemWrite = 1'b0; b1.ByteEn = 4'h0;
    b1.MemAdr = 32'h0; b1.MemWriteData = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", b0.MemReady, 1);
    chk("reset_valid", b0.MemValid, 0);
    chk("reset_rdata", b0.MemReadData, 0);
    chk("reset_error", b0.MemError, 0);

    issue0(1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, w);
    issue0(0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, w);
    issue0(1, 4'hF, 32'h20, 32'h11223344, 32'h0, 0, 1, w);
    issue0(1, 4'h5, 32'h20, 32'hAABBCCDD, 32'h0, 0, 1, w);
    issue0(0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 0, 1, w);
    chk("b2b_ready_low_cycles", w, LAT0 - 1);

    issue0(1, 4'hF, 32'h0, 32'h55667788, 32'h0, 0, 1, w);
    issue0(0, 4'hF, 32'h6, 32'h0, 32'h0, 1, 1, w);
    issue0(0, 4'hF, 32'h1000, 32'h0, 32'h0, 1, 1, w);
    issue0(1, 4'h0, 32'h0, 32'h99999999, 32'h0, 1, 1, w);
    issue0(1, 4'hF, 32'h2, 32'h99999999, 32'h0, 1, 1, w);
    issue0(0, 4'h1, 32'h0, 32'h0, 32'h55667788, 0, 1, w);

    issue0(1, 4'hF, 32'hFFC, 32'h0BADF00D, 32'h0, 0, 1, w);
    issue0(0, 4'hF, 32'hFFC, 32'h0, 32'h0BADF00D, 0, 1, w);

    issue0(1, 4'hF, 32'h40, 32'h01020304, 32'h0, 0, 1, w);
    drain();
    issue0(1, 4'hF, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0, w);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midwait_ready", b0.MemReady, 1);
    chk("midwait_valid", b0.MemValid, 0);
    issue0(0, 4'hF, 32'h40, 32'h0, 32'h01020304, 0, 1, w);
    drain();

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      b1.MemEn        = 1'b1;
      b1.MemWrite     = l1_we[i];
      b1.ByteEn       = l1_be[i];
      b1.MemAdr       = l1_ad[i];
      b1.MemWriteData = l1_wd[i];
      chk("l1_ready", b1.MemReady, 1);
      @(posedge clk);
      #1;
      q1.push_back('{l1_ed[i], l1_ee[i], cyc});
    end
    @(negedge clk);
    b1.MemEn = 1'b0;
    drain();

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the compute core's data-memory interface. It accepts MemEn/MemWrite/ByteEn/MemAdr/MemWriteData requests, services them against an internal word-organised storage array after a fixed number of wait cycles, and returns MemReadData with a completion strobe. It adds a MemReady/MemValid handshake so the core's pipeline can stall on multi-cycle memory.

Parameters:
BIT_COUNT, 32, width of MemAdr (32 or 64)
WORD_SIZE, 32, data word width; ByteEn width is WORD_SIZE/8
DEPTH_WORDS, 1024, storage depth in words; power of two
LATENCY, 2, cycles from request acceptance to the MemValid response; legal range 1..15

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
MemEn  input  1  request present
MemWrite  input  1  1 = write, 0 = read; qualified by MemEn
ByteEn  input  WORD_SIZE/8  byte lanes to write; bit i covers bits [8i+7:8i]
MemAdr  input  BIT_COUNT  byte address of the word
MemWriteData  input  WORD_SIZE  write data, lane-aligned
MemReady  output  1  responder can accept a request this cycle
MemValid  output  1  one-cycle response strobe
MemReadData  output  WORD_SIZE  read data; valid while MemValid=1
MemError  output  1  request faulted; valid while MemValid=1

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, MemReady=1, MemValid=0, MemError=0, MemReadData=0, latency counter=0. Storage array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- Acceptance: occurs on a rising edge where MemEn=1 and MemReady=1. The responder captures MemWrite, ByteEn, MemAdr and MemWriteData into request registers. After acceptance, inputs are don't-care until the next acceptance.
- Transition out of IDLE or RESP on acceptance:
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to WAIT and load the counter with LATENCY-2.
- WAIT: MemReady=0. The counter decrements each cycle. When the counter is 0, go to RESP on the next edge.
- RESP: lasts exactly 1 cycle with MemValid=1. MemReady=1 in RESP, so a new request can be accepted in the same cycle (back-to-back). Without a new request, RESP goes to IDLE.
- Fixed timing: a request accepted at edge N produces MemValid=1 during the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- Index: word index = captured MemAdr[$clog2(DEPTH_WORDS)+1:2].
- Error is computed from the captured request. MemError=1 if any of:
  - MemAdr[1:0] != 0
  - MemAdr >= DEPTH_WORDS*4
  - MemWrite=1 and ByteEn=0
- Write commit: happens on the edge entering RESP, and only for non-error requests. Only bytes whose ByteEn bit is set are updated; other bytes are unchanged. MemReadData=0 during a write response.
- Read: MemReadData = full stored word in RESP, regardless of ByteEn; the core truncates/extends. Error responses give MemReadData=0 and commit no write.
- MemReadData/MemError are registered. They hold their last value outside RESP but are only meaningful while MemValid=1.
- Read-after-write: a read accepted in the RESP cycle of a write to the same address returns the newly written data, because the write commits before the read samples storage.
- Reset mid-operation (in WAIT or RESP before the commit edge): the request is abandoned, no write occurs, and MemValid stays 0.
- MemEn=0 while MemReady=1: no state change.

Test Plan:
- Reset then read (LATENCY=2): hold reset=0 for 3 cycles, release, and check MemReady=1, MemValid=0. Next, write 0xDEADBEEF to 0x10 with ByteEn=1111, then read 0x10 → MemValid exactly 2 cycles after each acceptance; read returns 0xDEADBEEF with MemError=0.
- Partial write: 0x11223344 already at 0x20; write 0xAABBCCDD with ByteEn=0101 → a read of 0x20 returns 0x11BB33DD.
- Back-to-back: issue the read of 0x20 in the same cycle MemValid is high for the prior write → accepted in that cycle; MemReady=0 for exactly LATENCY-1 cycles; the read returns the new data.
- Errors, each giving MemValid=1, MemError=1, MemReadData=0, and storage at 0x0 unchanged afterwards:
  - read 0x6 (misaligned)
  - read 0x1000 with DEPTH_WORDS=1024 (out of range)
  - write 0x0 with ByteEn=0000
- Reset mid-WAIT: write 0xCAFEF00D to 0x40, assert reset one cycle after acceptance → no MemValid; a later read of 0x40 returns the prior contents.
- LATENCY=1 build: read accepted at edge N → MemValid in the cycle after edge N; MemReady never deasserts during continuous traffic.
